// File: rtl/spi_seq_pkg.sv
// ----------------------------------------------------------------------------
// spi_seq_pkg
// Shared types and helpers for the SPI word sequencer.
//   seq_state_t   : sequencer states (IDLE, LAUNCH, WAIT_DONE, CAPTURE)
//   seqLevelWidth : bit width needed to hold a FIFO occupancy of 0..depth
// ----------------------------------------------------------------------------
package spi_seq_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2,
        CAPTURE   = 2'd3
    } seq_state_t;

    // A level counter must represent "full" as well as "empty", hence the +1.
    function automatic int seqLevelWidth(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/spi_seq_fifo.sv
// ----------------------------------------------------------------------------
// spi_seq_fifo
// Synchronous first-word-fall-through FIFO with an occupancy output.
// A push while full is ignored (even alongside a pop), a pop while empty is
// ignored, and pointers wrap naturally because DEPTH is a power of two.
// Ports:
//   i_clk, i_rst   : clock, synchronous active-high reset
//   i_push, i_pushData, o_full   : write side
//   i_pop, o_popData, o_empty    : read side (o_popData is the current head)
//   o_level        : number of stored entries, 0..DEPTH
// ----------------------------------------------------------------------------
module spi_seq_fifo
    import spi_seq_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_pushData,
    output logic                   o_full,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_popData,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_level
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = seqLevelWidth(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wrPtr;
    logic [PTR_W-1:0]   r_rdPtr;
    logic [LEVEL_W-1:0] r_level;
    logic               w_doPush;
    logic               w_doPop;

    assign o_full    = (r_level == LEVEL_W'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_doPush  = i_push && !o_full;
    assign w_doPop   = i_pop && !o_empty;
    assign o_popData = r_mem[r_rdPtr];
    assign o_level   = r_level;

    // Storage array needs no reset; only the pointers define what is valid.
    always_ff @(posedge i_clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= i_pushData;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_level <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + PTR_W'(1);
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + PTR_W'(1);
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_level <= r_level + LEVEL_W'(1);
                2'b01:   r_level <= r_level - LEVEL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spi_word_sequencer.sv
// ----------------------------------------------------------------------------
// spi_word_sequencer
// Word-level front end for the SPI shifter: buffers TX words, generates SCLK,
// runs the process_next_word / processing_word handshake one word at a time
// and captures each received word into an RX FIFO.
// Ports:
//   master_clock, do_reset        : clock, synchronous active-high reset
//   tx_valid/tx_ready/tx_data     : TX FIFO push side
//   rx_valid/rx_ready/rx_data     : RX FIFO pop side (FWFT head)
//   sclk, process_next_word, data_word_send, processing_word,
//   data_word_recv                : shifter-side connections
//   busy                          : state is not IDLE
//   tx_level, rx_level            : FIFO occupancies
//   rx_overflow                   : sticky dropped-word flag
// Build option:
//   SPI_SEQ_RX_DROP_EN : when defined, words are launched regardless of RX
//   space and a capture into a full RX FIFO is dropped and flagged. When not
//   defined, launches wait for RX space and rx_overflow is tied low.
// ----------------------------------------------------------------------------
module spi_word_sequencer
    import spi_seq_pkg::*;
#(
    parameter int   SPI_WORD_LEN = 8,
    parameter int   FIFO_DEPTH   = 4,
    parameter int   CLK_DIV      = 4,
    parameter logic CPOL         = 1'b0
) (
    input  logic                        master_clock,
    input  logic                        do_reset,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    input  logic [SPI_WORD_LEN-1:0]     tx_data,
    output logic                        rx_valid,
    input  logic                        rx_ready,
    output logic [SPI_WORD_LEN-1:0]     rx_data,
    output logic                        sclk,
    output logic                        process_next_word,
    output logic [SPI_WORD_LEN-1:0]     data_word_send,
    input  logic                        processing_word,
    input  logic [SPI_WORD_LEN-1:0]     data_word_recv,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] tx_level,
    output logic [$clog2(FIFO_DEPTH):0] rx_level,
    output logic                        rx_overflow
);

    localparam int CNT_W = $clog2(CLK_DIV);

    seq_state_t              r_state;
    seq_state_t              w_nextState;
    logic                    r_processNext;
    logic                    w_nextProcess;
    logic [SPI_WORD_LEN-1:0] r_dataSend;
    logic [CNT_W-1:0]        r_divCnt;
    logic                    r_sclk;
    logic                    w_txPop;
    logic                    w_rxPush;
    logic                    w_txFull;
    logic                    w_txEmpty;
    logic                    w_rxFull;
    logic                    w_rxEmpty;
    logic                    w_startGate;
    logic [SPI_WORD_LEN-1:0] w_txHead;

    spi_seq_fifo #(
        .WIDTH (SPI_WORD_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_txFifo (
        .i_clk      (master_clock),
        .i_rst      (do_reset),
        .i_push     (tx_valid),
        .i_pushData (tx_data),
        .o_full     (w_txFull),
        .i_pop      (w_txPop),
        .o_popData  (w_txHead),
        .o_empty    (w_txEmpty),
        .o_level    (tx_level)
    );

    spi_seq_fifo #(
        .WIDTH (SPI_WORD_LEN),
        .DEPTH (FIFO_DEPTH)
    ) u_rxFifo (
        .i_clk      (master_clock),
        .i_rst      (do_reset),
        .i_push     (w_rxPush),
        .i_pushData (data_word_recv),
        .o_full     (w_rxFull),
        .i_pop      (rx_ready),
        .o_popData  (rx_data),
        .o_empty    (w_rxEmpty),
        .o_level    (rx_level)
    );

    assign tx_ready          = !w_txFull;
    assign rx_valid          = !w_rxEmpty;
    assign busy              = (r_state != IDLE);
    assign sclk              = r_sclk;
    assign process_next_word = r_processNext;
    assign data_word_send    = r_dataSend;

`ifdef SPI_SEQ_RX_DROP_EN
    assign w_startGate = !w_txEmpty;
`else
    // The gate is only consulted in IDLE, where no word is in flight, so
    // "rx_level + in-flight < depth" reduces to "RX not full".
    assign w_startGate = !w_txEmpty && !w_rxFull;
`endif

    always_ff @(posedge master_clock) begin
        if (do_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextProcess = 1'b0;
        w_txPop       = 1'b0;
        w_rxPush      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_startGate) begin
                    w_nextState   = LAUNCH;
                    w_nextProcess = 1'b1;
                    w_txPop       = 1'b1;
                end
            end
            LAUNCH: begin
                if (processing_word) begin
                    w_nextState = WAIT_DONE;
                end else begin
                    w_nextProcess = 1'b1;
                end
            end
            WAIT_DONE: begin
                if (!processing_word) begin
                    w_nextState = CAPTURE;
                end
            end
            CAPTURE: begin
                w_rxPush    = 1'b1;
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The outgoing word is latched at launch and held until the next launch,
    // so the shifter may sample it at any point during the transfer.
    always_ff @(posedge master_clock) begin
        if (do_reset) begin
            r_processNext <= 1'b0;
            r_dataSend    <= '0;
        end else begin
            r_processNext <= w_nextProcess;
            if (w_txPop) begin
                r_dataSend <= w_txHead;
            end
        end
    end

    // SCLK is parked at CPOL while idle and on the edge that returns to IDLE,
    // which guarantees every word starts from a clean idle level.
    always_ff @(posedge master_clock) begin
        if (do_reset) begin
            r_divCnt <= '0;
            r_sclk   <= CPOL;
        end else if (r_state == IDLE || w_nextState == IDLE) begin
            r_divCnt <= '0;
            r_sclk   <= CPOL;
        end else if (r_divCnt == CNT_W'(CLK_DIV - 1)) begin
            r_divCnt <= '0;
            r_sclk   <= !r_sclk;
        end else begin
            r_divCnt <= r_divCnt + CNT_W'(1);
        end
    end

`ifdef SPI_SEQ_RX_DROP_EN
    logic r_rxOverflow;

    // The RX FIFO already ignores the push when full; this only records it.
    always_ff @(posedge master_clock) begin
        if (do_reset) begin
            r_rxOverflow <= 1'b0;
        end else if (w_rxPush && w_rxFull) begin
            r_rxOverflow <= 1'b1;
        end
    end

    assign rx_overflow = r_rxOverflow;
`else
    assign rx_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_spi_word_sequencer.sv
// ----------------------------------------------------------------------------
// tb_spi_word_sequencer
// Directed bench for spi_word_sequencer with a loopback shifter model: every
// word sent comes back as the received word. Accepted TX words are queued as
// expected RX words; a monitor pops and compares whenever an RX word is taken.
// ----------------------------------------------------------------------------
module tb_spi_word_sequencer;

    localparam int   WLEN         = 8;
    localparam int   DEPTH        = 4;
    localparam int   CLK_DIV      = 4;
    localparam logic CPOL         = 1'b0;
    localparam int   SHIFT_CYCLES = 16;

    logic            master_clock;
    logic            do_reset;
    logic            tx_valid;
    logic            tx_ready;
    logic [WLEN-1:0] tx_data;
    logic            rx_valid;
    logic            rx_ready;
    logic [WLEN-1:0] rx_data;
    logic            sclk;
    logic            process_next_word;
    logic [WLEN-1:0] data_word_send;
    logic            processing_word;
    logic [WLEN-1:0] data_word_recv;
    logic            busy;
    logic [2:0]      tx_level;
    logic [2:0]      rx_level;
    logic            rx_overflow;

    int              totalCount = 0;
    int              badCount   = 0;
    int              rxCount    = 0;
    logic [WLEN-1:0] expQ [$];

    spi_word_sequencer #(
        .SPI_WORD_LEN (WLEN),
        .FIFO_DEPTH   (DEPTH),
        .CLK_DIV      (CLK_DIV),
        .CPOL         (CPOL)
    ) dut (
        .master_clock      (master_clock),
        .do_reset          (do_reset),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .tx_data           (tx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .rx_data           (rx_data),
        .sclk              (sclk),
        .process_next_word (process_next_word),
        .data_word_send    (data_word_send),
        .processing_word   (processing_word),
        .data_word_recv    (data_word_recv),
        .busy              (busy),
        .tx_level          (tx_level),
        .rx_level          (rx_level),
        .rx_overflow       (rx_overflow)
    );

    initial begin
        master_clock = 1'b0;
        forever #5 master_clock = ~master_clock;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        totalCount++;
        if (actual !== expected) begin
            badCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic cycle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge master_clock);
            #1;
        end
    endtask

    // One push attempt: accepted reports whether tx_ready was high at the edge.
    task automatic applyStimulus(input logic [WLEN-1:0] word, input bit expectRx,
                                 output bit accepted);
        tx_data  = word;
        tx_valid = 1'b1;
        accepted = tx_ready;
        @(posedge master_clock);
        #1;
        tx_valid = 1'b0;
        if (accepted && expectRx) expQ.push_back(word);
    endtask

    task automatic pushUntilAccepted(input logic [WLEN-1:0] word, input bit expectRx);
        bit acc;
        int tries;
        acc   = 1'b0;
        tries = 0;
        while (!acc && tries < 500) begin
            applyStimulus(word, expectRx, acc);
            tries++;
        end
        checkOutput("push_accept_timeout", {31'd0, acc}, 32'd1);
    endtask

    task automatic waitDrained(input string name);
        int i;
        for (i = 0; i < 3000 && !(expQ.size() == 0 && !busy && tx_level == 0); i++) cycle(1);
        checkOutput(name, {31'd0, (expQ.size() == 0 && !busy && tx_level == 0)}, 32'd1);
    endtask

    // Loopback shifter: answers a start request, stays busy for a while, then
    // returns the sent word. It abandons the word if the sequencer goes idle.
    initial begin : shifterModel
        bit shBusy;
        int shCnt;
        shBusy          = 1'b0;
        shCnt           = 0;
        processing_word = 1'b0;
        data_word_recv  = '0;
        forever begin
            @(posedge master_clock);
            #1;
            if (shBusy && !busy) begin
                shBusy          = 1'b0;
                processing_word = 1'b0;
            end else if (!shBusy) begin
                if (process_next_word) begin
                    shBusy          = 1'b1;
                    processing_word = 1'b1;
                    shCnt           = SHIFT_CYCLES;
                end
            end else if (shCnt == 0) begin
                data_word_recv  = data_word_send;
                processing_word = 1'b0;
                shBusy          = 1'b0;
            end else begin
                shCnt--;
            end
        end
    end

    // Scoreboard monitor: every word taken from the RX FIFO must match the
    // oldest expected word.
    always @(negedge master_clock) begin
        if (!do_reset && rx_valid && rx_ready) begin
            rxCount++;
            if (expQ.size() == 0) begin
                totalCount++;
                badCount++;
                $display("[TB] FAIL rx_unexpected: got 0x%0h expected no word", rx_data);
            end else begin
                checkOutput("rx_data_order", {24'd0, rx_data}, {24'd0, expQ.pop_front()});
            end
        end
    end

    // SCLK monitor: half-periods of CLK_DIV cycles while active, and the idle
    // level every time the sequencer drops back to IDLE.
    int   sclkCnt  = 0;
    logic prevBusy = 1'b0;
    logic prevSclk = 1'b0;
    always @(negedge master_clock) begin
        if (busy && !prevBusy) begin
            sclkCnt = 0;
        end else if (busy) begin
            sclkCnt++;
            if (sclk != prevSclk) begin
                checkOutput("sclk_half_period", sclkCnt, CLK_DIV);
                sclkCnt = 0;
            end
        end
        if (!busy && prevBusy) begin
            checkOutput("sclk_idle_level", {31'd0, sclk}, {31'd0, CPOL});
        end
        prevBusy = busy;
        prevSclk = sclk;
    end

    initial begin : mainSeq
        bit acc;
        int i;
        tx_valid = 1'b0;
        tx_data  = '0;
        rx_ready = 1'b0;
        do_reset = 1'b1;
        cycle(3);
        do_reset = 1'b0;

        $display("[TB] reset values");
        checkOutput("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        checkOutput("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        checkOutput("rst_sclk", {31'd0, sclk}, {31'd0, CPOL});
        checkOutput("rst_pnw", {31'd0, process_next_word}, 32'd0);
        checkOutput("rst_send", {24'd0, data_word_send}, 32'd0);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        checkOutput("rst_tx_level", {29'd0, tx_level}, 32'd0);
        checkOutput("rst_rx_level", {29'd0, rx_level}, 32'd0);
        checkOutput("rst_overflow", {31'd0, rx_overflow}, 32'd0);

        $display("[TB] single word 0xA5");
        applyStimulus(8'hA5, 1'b1, acc);
        checkOutput("t1_tx_level", {29'd0, tx_level}, 32'd1);
        checkOutput("t1_pnw_early", {31'd0, process_next_word}, 32'd0);
        cycle(1);
        checkOutput("t1_pnw_rise", {31'd0, process_next_word}, 32'd1);
        checkOutput("t1_send", {24'd0, data_word_send}, 32'hA5);
        checkOutput("t1_tx_popped", {29'd0, tx_level}, 32'd0);
        for (i = 0; i < 200 && !rx_valid; i++) cycle(1);
        checkOutput("t1_rx_valid", {31'd0, rx_valid}, 32'd1);
        checkOutput("t1_rx_data", {24'd0, rx_data}, 32'hA5);
        checkOutput("t1_rx_level", {29'd0, rx_level}, 32'd1);
        rx_ready = 1'b1;
        cycle(2);
        checkOutput("t1_rx_empty", {29'd0, rx_level}, 32'd0);

        $display("[TB] fill TX while a word is in flight");
        applyStimulus(8'h11, 1'b1, acc);
        cycle(2);
        checkOutput("t2_busy", {31'd0, busy}, 32'd1);
        applyStimulus(8'h22, 1'b1, acc);
        applyStimulus(8'h33, 1'b1, acc);
        applyStimulus(8'h44, 1'b1, acc);
        applyStimulus(8'h55, 1'b1, acc);
        checkOutput("t2_tx_ready_full", {31'd0, tx_ready}, 32'd0);
        checkOutput("t2_tx_level_full", {29'd0, tx_level}, 32'd4);
        applyStimulus(8'h66, 1'b1, acc);
        checkOutput("t2_fifth_ignored", {31'd0, acc}, 32'd0);
        checkOutput("t2_tx_level_hold", {29'd0, tx_level}, 32'd4);
        waitDrained("t2_drain_timeout");
        checkOutput("t2_rx_count", rxCount, 32'd6);

        $display("[TB] RX backpressure with six words");
        rx_ready = 1'b0;
        for (int w = 0; w < 6; w++) begin
`ifdef SPI_SEQ_RX_DROP_EN
            pushUntilAccepted(8'h80 + 8'(w), (w < 4));
`else
            pushUntilAccepted(8'h80 + 8'(w), 1'b1);
`endif
        end
`ifdef SPI_SEQ_RX_DROP_EN
        for (i = 0; i < 1000 && !(tx_level == 0 && !busy); i++) cycle(1);
        cycle(5);
        checkOutput("t4_rx_level", {29'd0, rx_level}, 32'd4);
        checkOutput("t4_tx_level", {29'd0, tx_level}, 32'd0);
        checkOutput("t4_overflow", {31'd0, rx_overflow}, 32'd1);
`else
        for (i = 0; i < 1000 && !(rx_level == 4 && !busy); i++) cycle(1);
        cycle(20);
        checkOutput("t4_rx_level", {29'd0, rx_level}, 32'd4);
        checkOutput("t4_tx_level", {29'd0, tx_level}, 32'd2);
        checkOutput("t4_busy_stall", {31'd0, busy}, 32'd0);
        checkOutput("t4_overflow", {31'd0, rx_overflow}, 32'd0);
`endif
        rx_ready = 1'b1;
        waitDrained("t4_drain_timeout");
        cycle(3);
        checkOutput("t4_rx_drained", {31'd0, rx_valid}, 32'd0);

        $display("[TB] reset during WAIT_DONE");
        applyStimulus(8'h3C, 1'b0, acc);
        applyStimulus(8'h3D, 1'b0, acc);
        for (i = 0; i < 100 && !(busy && !process_next_word && processing_word); i++) cycle(1);
        checkOutput("t5_reach_wait", {31'd0, (busy && !process_next_word && processing_word)}, 32'd1);
        checkOutput("t5_tx_pending", {29'd0, tx_level}, 32'd1);
        do_reset = 1'b1;
        cycle(1);
        do_reset = 1'b0;
        checkOutput("t5_busy", {31'd0, busy}, 32'd0);
        checkOutput("t5_sclk", {31'd0, sclk}, {31'd0, CPOL});
        checkOutput("t5_tx_level", {29'd0, tx_level}, 32'd0);
        checkOutput("t5_rx_level", {29'd0, rx_level}, 32'd0);
        checkOutput("t5_pnw", {31'd0, process_next_word}, 32'd0);
        checkOutput("t5_overflow", {31'd0, rx_overflow}, 32'd0);
        cycle(40);
        checkOutput("t5_no_rx_push", {31'd0, rx_valid}, 32'd0);
        checkOutput("t5_still_idle", {31'd0, busy}, 32'd0);

        $display("[TB] push coinciding with launch pop");
        applyStimulus(8'h5A, 1'b1, acc);
        applyStimulus(8'hC3, 1'b1, acc);
        checkOutput("t6_tx_level", {29'd0, tx_level}, 32'd1);
        checkOutput("t6_pnw", {31'd0, process_next_word}, 32'd1);
        checkOutput("t6_send", {24'd0, data_word_send}, 32'h5A);
        waitDrained("t6_drain_timeout");
        cycle(3);

        checkOutput("final_queue_empty", expQ.size(), 32'd0);
`ifdef SPI_SEQ_RX_DROP_EN
        checkOutput("final_rx_count", rxCount, 32'd12);
`else
        checkOutput("final_rx_count", rxCount, 32'd14);
`endif

        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $finish;
    end

    // Absolute backstop so the run always ends.
    initial begin : watchdog
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        badCount++;
        $display("test done: total=%0d bad=%0d", totalCount, badCount);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
